// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encoding, RV32I opcodes, select/alu_op and branch funct3 codes
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXE_ADDR = 4'd2,
        EXE_R    = 4'd3,
        EXE_I    = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BR       = 4'd9,
        JUMP     = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;

    localparam logic [1:0] SRC_B_RD2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_4      = 2'b10;

    localparam logic [1:0] RES_ALU      = 2'b00;
    localparam logic [1:0] RES_DATA     = 2'b01;
    localparam logic [1:0] RES_PC4      = 2'b10;
    localparam logic [1:0] RES_IMM      = 2'b11;

    localparam logic [1:0] ALU_ADD      = 2'b00;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_RFUNCT   = 2'b10;
    localparam logic [1:0] ALU_IFUNCT   = 2'b11;

    localparam logic [2:0] F3_BEQ       = 3'b000;
    localparam logic [2:0] F3_BNE       = 3'b001;
    localparam logic [2:0] F3_BLT       = 3'b100;
    localparam logic [2:0] F3_BGE       = 3'b101;
    localparam logic [2:0] F3_BLTU      = 3'b110;
    localparam logic [2:0] F3_BGEU      = 3'b111;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - IR fields, ALU flags, memory handshake and datapath control lines
interface mc_ctrl_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       mem_req;
    logic       we_mem;
    logic       sel_mem_addr;
    logic       we_ir;
    logic       we_rf;
    logic [1:0] sel_alu_src_a;
    logic [1:0] sel_alu_src_b;
    logic [1:0] sel_result;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       sel_pc_src;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  op, funct3, zero, lt, ltu, mem_ready,
        output mem_req, we_mem, sel_mem_addr, we_ir, we_rf,
               sel_alu_src_a, sel_alu_src_b, sel_result, alu_op,
               pc_update, sel_pc_src, trap, state
    );

    modport slave (
        output op, funct3, zero, lt, ltu, mem_ready,
        input  mem_req, we_mem, sel_mem_addr, we_ir, we_rf,
               sel_alu_src_a, sel_alu_src_b, sel_result, alu_op,
               pc_update, sel_pc_src, trap, state
    );
endinterface

// File: rtl/mc_branch_cond.sv
// rtl/mc_branch_cond.sv - branch-taken decode from funct3 and live ALU flags
module mc_branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       take,
    output logic       illegal
);

    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  take = zero;
            F3_BNE:  take = !zero;
            F3_BLT:  take = lt;
            F3_BGE:  take = !lt;
            F3_BLTU: take = ltu;
            F3_BGEU: take = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I control FSM with ready-handshake memory waits.
// MC_FSM_TRAP_EN adds the TRAP state, memory timeout counter and trap output.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    state_t state_q;
    state_t state_d;
    logic   br_take;
    logic   br_illegal;
    logic   timeout;

    mc_branch_cond u_branch_cond (
        .funct3  (bus.funct3),
        .zero    (bus.zero),
        .lt      (bus.lt),
        .ltu     (bus.ltu),
        .take    (br_take),
        .illegal (br_illegal)
    );

`ifdef MC_FSM_TRAP_EN
    localparam state_t ILLEGAL_NEXT = TRAP;

    logic            is_wait;
    logic [TO_W-1:0] to_cnt;

    assign is_wait = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // mem_ready has priority: timeout only fires on a cycle the request is still stalled
    assign timeout = is_wait && !bus.mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state_d != state_q) begin
            to_cnt <= '0;
        end else if (is_wait && !bus.mem_ready) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    localparam state_t ILLEGAL_NEXT = FETCH;

    logic [TO_W-1:0] unused_to_w;

    assign unused_to_w = '0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready)  state_d = DECODE;
                else if (timeout)   state_d = TRAP;
            end
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_AUIPC: state_d = EXE_ADDR;
                    OP_R:                      state_d = EXE_R;
                    OP_I:                      state_d = EXE_I;
                    OP_LUI:                    state_d = LUI;
                    default:                   state_d = ILLEGAL_NEXT;
                endcase
            end
            EXE_ADDR: begin
                case (bus.op)
                    OP_LW:            state_d = MEM_RD;
                    OP_SW:            state_d = MEM_WR;
                    OP_BRANCH:        state_d = BR;
                    OP_JAL, OP_JALR:  state_d = JUMP;
                    OP_AUIPC:         state_d = WB_ALU;
                    default:          state_d = FETCH;
                endcase
            end
            MEM_RD: begin
                if (bus.mem_ready)  state_d = WB_MEM;
                else if (timeout)   state_d = TRAP;
            end
            MEM_WR: begin
                if (bus.mem_ready)  state_d = FETCH;
                else if (timeout)   state_d = TRAP;
            end
            EXE_R, EXE_I:                 state_d = WB_ALU;
            WB_MEM, WB_ALU, JUMP, LUI:    state_d = FETCH;
            BR:                           state_d = br_illegal ? ILLEGAL_NEXT : FETCH;
            TRAP:                         state_d = TRAP;
            default:                      state_d = FETCH;
        endcase
    end

    // Gated by rst combinationally so an asynchronous reset silences writes within the cycle
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.we_mem        = 1'b0;
        bus.sel_mem_addr  = 1'b0;
        bus.we_ir         = 1'b0;
        bus.we_rf         = 1'b0;
        bus.sel_alu_src_a = SRC_A_PC;
        bus.sel_alu_src_b = SRC_B_RD2;
        bus.sel_result    = RES_ALU;
        bus.alu_op        = ALU_ADD;
        bus.pc_update     = 1'b0;
        bus.sel_pc_src    = 1'b0;
        bus.trap          = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    bus.mem_req       = 1'b1;
                    bus.sel_alu_src_b = SRC_B_4;
                    bus.sel_result    = RES_PC4;
                    bus.we_ir         = bus.mem_ready;
                    bus.pc_update     = bus.mem_ready;
                end
                EXE_ADDR: begin
                    bus.sel_alu_src_a = (bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_JALR)
                                        ? SRC_A_RD1 : SRC_A_OLD_PC;
                    bus.sel_alu_src_b = SRC_B_IMM;
                end
                MEM_RD: begin
                    bus.mem_req      = 1'b1;
                    bus.sel_mem_addr = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_req      = 1'b1;
                    bus.we_mem       = 1'b1;
                    bus.sel_mem_addr = 1'b1;
                end
                WB_MEM: begin
                    bus.we_rf      = 1'b1;
                    bus.sel_result = RES_DATA;
                end
                EXE_R: begin
                    bus.sel_alu_src_a = SRC_A_RD1;
                    bus.alu_op        = ALU_RFUNCT;
                end
                EXE_I: begin
                    bus.sel_alu_src_a = SRC_A_RD1;
                    bus.sel_alu_src_b = SRC_B_IMM;
                    bus.alu_op        = ALU_IFUNCT;
                end
                WB_ALU: bus.we_rf = 1'b1;
                BR: begin
                    bus.sel_alu_src_a = SRC_A_RD1;
                    bus.alu_op        = ALU_SUB;
                    bus.sel_pc_src    = 1'b1;
                    bus.pc_update     = br_take && !br_illegal;
                end
                JUMP: begin
                    bus.we_rf      = 1'b1;
                    bus.sel_result = RES_PC4;
                    bus.pc_update  = 1'b1;
                    bus.sel_pc_src = 1'b1;
                end
                LUI: begin
                    bus.we_rf      = 1'b1;
                    bus.sel_result = RES_IMM;
                end
`ifdef MC_FSM_TRAP_EN
                TRAP: bus.trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm; expectations follow MC_FSM_TRAP_EN
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic clk;
    logic rst;
    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, mem_req, we_mem, sel_mem_addr, we_ir, we_rf, src_a, src_b, sel_result, alu_op, pc_update, sel_pc_src, trap}
    logic [19:0] outs;
    assign outs = {bus.state, bus.mem_req, bus.we_mem, bus.sel_mem_addr, bus.we_ir, bus.we_rf,
                   bus.sel_alu_src_a, bus.sel_alu_src_b, bus.sel_result, bus.alu_op,
                   bus.pc_update, bus.sel_pc_src, bus.trap};

    localparam logic [19:0] E_RESET  = 20'h0;
    localparam logic [19:0] E_DECODE = {DECODE, 5'b00000, 8'h00, 3'b000};
    localparam logic [19:0] E_EXE_R  = {EXE_R,  5'b00000, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000};
    localparam logic [19:0] E_EXE_I  = {EXE_I,  5'b00000, 2'b10, 2'b01, 2'b00, 2'b11, 3'b000};
    localparam logic [19:0] E_WB_ALU = {WB_ALU, 5'b00001, 8'h00, 3'b000};
    localparam logic [19:0] E_MEM_RD = {MEM_RD, 5'b10100, 8'h00, 3'b000};
    localparam logic [19:0] E_MEM_WR = {MEM_WR, 5'b11100, 8'h00, 3'b000};
    localparam logic [19:0] E_WB_MEM = {WB_MEM, 5'b00001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000};
    localparam logic [19:0] E_JUMP   = {JUMP,   5'b00001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b110};
    localparam logic [19:0] E_LUI    = {LUI,    5'b00001, 2'b00, 2'b00, 2'b11, 2'b00, 3'b000};
    localparam logic [19:0] E_TRAP   = {TRAP,   5'b00000, 8'h00, 3'b001};

    function automatic logic [19:0] e_fetch(input logic mr);
        return {FETCH, 1'b1, 1'b0, 1'b0, mr, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, mr, 2'b00};
    endfunction

    function automatic logic [19:0] e_addr(input logic [1:0] sa);
        return {EXE_ADDR, 5'b00000, sa, 2'b01, 2'b00, 2'b00, 3'b000};
    endfunction

    function automatic logic [19:0] e_br(input logic tk);
        return {BR, 5'b00000, 2'b10, 2'b00, 2'b00, 2'b01, tk, 1'b1, 1'b0};
    endfunction

    logic [19:0] sb[$];
    logic        mr_q[$];
    int          n_cmp;
    int          n_fail;

    task automatic push(input logic mr, input logic [19:0] e);
        mr_q.push_back(mr);
        sb.push_back(e);
    endtask

    task automatic step(output logic [19:0] got, output logic [19:0] want);
        bus.mem_ready = mr_q.pop_front();
        @(negedge clk);
        got  = outs;
        want = sb.pop_front();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input logic l, input logic lu);
        bus.op = op; bus.funct3 = f3; bus.zero = z; bus.lt = l; bus.ltu = lu;
    endtask

    task automatic test_reset();
        logic [19:0] got, want;
        int k = 0;
        rst = 1'b1;
        push(1'b1, E_RESET);
        push(1'b1, E_RESET);
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL reset[%0d]: got %h required %h", k, got, want); end
            k++;
        end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [19:0] got, want;
        int k = 0;
        set_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, E_EXE_R);
        push(1'b1, E_WB_ALU);
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, E_EXE_R);
        push(1'b1, E_WB_ALU);
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL rtype[%0d]: got %h required %h", k, got, want); end
            k++;
        end
    endtask

    task automatic test_lw_wait();
        logic [19:0] got, want;
        int k = 0;
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, e_addr(2'b10));
        for (int i = 0; i < 3; i++) push(1'b0, E_MEM_RD);
        push(1'b1, E_MEM_RD);
        push(1'b0, E_WB_MEM);
        set_instr(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            if (k == 1) set_instr(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL lw_wait[%0d]: got %h required %h", k, got, want); end
            k++;
        end
    endtask

    task automatic test_sw();
        logic [19:0] got, want;
        int k = 0;
        set_instr(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, e_addr(2'b10));
        push(1'b0, E_MEM_WR);
        push(1'b1, E_MEM_WR);
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL sw[%0d]: got %h required %h", k, got, want); end
            k++;
        end
    endtask

    task automatic test_branch();
        logic [19:0] got, want;
        logic [2:0]  f3s[8]  = '{3'b001, 3'b001, 3'b110, 3'b110, 3'b000, 3'b101, 3'b100, 3'b111};
        logic        zs[8]   = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
        logic        ls[8]   = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1};
        logic        lus[8]  = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
        logic        tks[8]  = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
        for (int c = 0; c < 8; c++) begin
            int k = 0;
            set_instr(OP_BRANCH, f3s[c], zs[c], ls[c], lus[c]);
            push(1'b1, e_fetch(1'b1));
            push(1'b1, E_DECODE);
            push(1'b1, e_addr(2'b01));
            push(1'b1, e_br(tks[c]));
            while (sb.size() != 0) begin
                step(got, want); n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL branch%0d[%0d]: got %h required %h", c, k, got, want);
                end
                k++;
            end
        end
    endtask

    task automatic test_jumps();
        logic [19:0] got, want;
        logic [6:0]  ops[5] = '{OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_I};
        for (int c = 0; c < 5; c++) begin
            int k = 0;
            set_instr(ops[c], 3'b000, 1'b0, 1'b0, 1'b0);
            push(1'b1, e_fetch(1'b1));
            push(1'b1, E_DECODE);
            case (c)
                0: begin push(1'b1, e_addr(2'b01)); push(1'b1, E_JUMP); end
                1: begin push(1'b1, e_addr(2'b10)); push(1'b1, E_JUMP); end
                2: begin push(1'b1, e_addr(2'b01)); push(1'b1, E_WB_ALU); end
                3: push(1'b1, E_LUI);
                default: begin push(1'b1, E_EXE_I); push(1'b1, E_WB_ALU); end
            endcase
            while (sb.size() != 0) begin
                step(got, want); n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL jumps%0d[%0d]: got %h required %h", c, k, got, want);
                end
                k++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [19:0] got, want;
        for (int c = 0; c < 2; c++) begin
            int k = 0;
            if (c == 0) set_instr(7'b1111111, 3'b000, 1'b1, 1'b1, 1'b1);
            else        set_instr(OP_BRANCH,  3'b010, 1'b1, 1'b1, 1'b1);
            push(1'b1, e_fetch(1'b1));
            push(1'b1, E_DECODE);
            if (c == 1) begin
                push(1'b1, e_addr(2'b01));
                push(1'b1, e_br(1'b0));
            end
`ifdef MC_FSM_TRAP_EN
            push(1'b1, E_TRAP);
            push(1'b1, E_TRAP);
`else
            push(1'b0, e_fetch(1'b0));
`endif
            while (sb.size() != 0) begin
                step(got, want); n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL illegal%0d[%0d]: got %h required %h", c, k, got, want);
                end
                k++;
            end
            do_reset();
        end
    endtask

    task automatic test_timeout();
        logic [19:0] got, want;
        int k = 0;
        set_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef MC_FSM_TRAP_EN
        for (int i = 0; i < 4; i++) push(1'b0, e_fetch(1'b0));
        for (int i = 0; i < 3; i++) push(1'b1, E_TRAP);
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL timeout_trap[%0d]: got %h required %h", k, got, want); end
            k++;
        end
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b0, e_fetch(1'b0));
`else
        for (int i = 0; i < 20; i++) push(1'b0, e_fetch(1'b0));
`endif
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, E_EXE_R);
        push(1'b1, E_WB_ALU);
        k = 0;
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL timeout_late[%0d]: got %h required %h", k, got, want); end
            k++;
        end
    endtask

    task automatic test_rst_mid();
        logic [19:0] got, want;
        int k = 0;
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        push(1'b1, e_addr(2'b10));
        push(1'b1, E_MEM_RD);
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL rst_mid_pre[%0d]: got %h required %h", k, got, want); end
            k++;
        end
        bus.mem_ready = 1'b0;
        sb.push_back(E_WB_MEM);
        @(negedge clk);
        want = sb.pop_front(); n_cmp++;
        if (outs !== want) begin n_fail++; $display("FAIL rst_mid_wb: got %h required %h", outs, want); end
        #1 rst = 1'b1;
        sb.push_back(E_RESET);
        #1;
        want = sb.pop_front(); n_cmp++;
        if (outs !== want) begin n_fail++; $display("FAIL rst_mid_zero: got %h required %h", outs, want); end
        @(posedge clk);
        #1 rst = 1'b0;
        push(1'b0, e_fetch(1'b0));
        push(1'b1, e_fetch(1'b1));
        push(1'b1, E_DECODE);
        k = 0;
        while (sb.size() != 0) begin
            step(got, want); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL rst_mid_post[%0d]: got %h required %h", k, got, want); end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jumps();
        test_illegal();
        test_timeout();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multi-cycle control FSM for the RISC-V core, the successor to the fixed-latency controller. It sequences fetch, decode, execute, memory and write-back across multiple cycles and covers the full RV32I control-flow set: all six branches, JAL, JALR, LUI and AUIPC. Memory accesses use a ready handshake with variable wait states, and an optional trap path handles illegal encodings and memory timeouts. It sits between the IR decode fields and the datapath select/enable lines.

## Interface
- MEM_TIMEOUT, 16: maximum cycles one memory request may remain outstanding; must be ≥1.
- TO_W, $clog2(MEM_TIMEOUT+1): timeout counter width (derived, not overridden).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- op  in  7  opcode from IR.
- funct3  in  3  funct3 from IR.
- zero, lt, ltu  in  1 each  ALU flags from the live (unregistered) ALU result.
- mem_ready  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory request valid.
- we_mem  out  1  write qualifier for mem_req.
- sel_mem_addr  out  1  0 = PC, 1 = alu_reg.
- we_ir, we_rf  out  1  IR and register-file write enables.
- sel_alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rd1.
- sel_alu_src_b  out  2  00 = rd2, 01 = imm, 10 = const 4.
- sel_result  out  2  00 = alu_reg, 01 = data_reg, 10 = pc_plus4_reg, 11 = imm.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = I-type funct.
- pc_update  out  1  PC write enable.
- sel_pc_src  out  1  0 = live ALU result, 1 = alu_reg.
- trap  out  1  core trapped. Tied to 0 when the trap feature is compiled out.
- state  out  4  current state, for debug and bench.

## Operation
- Reset value of every output is 0 while rst is high. `state` resets to FETCH.
- FETCH: mem_req=1, sel_mem_addr=0, src_a=00, src_b=10, alu_op=00, sel_result=10. we_ir and pc_update are asserted only in the cycle mem_ready=1, which is also the exit to DECODE.
- DECODE (no outputs), next state by opcode:
  - LW or SW → EXE_ADDR.
  - R-type → EXE_R.
  - I-arith → EXE_I.
  - BRANCH, JAL, JALR or AUIPC → EXE_ADDR.
  - LUI → LUI.
  - Any other opcode → ILLEGAL handling.
- EXE_ADDR: src_b=01, alu_op=00. src_a=10 for LW, SW and JALR; src_a=01 otherwise. Next state:
  - MEM_RD for LW.
  - MEM_WR for SW.
  - BR for BRANCH.
  - JUMP for JAL and JALR.
  - WB_ALU for AUIPC.
- MEM_RD: mem_req=1, sel_mem_addr=1. Waits for mem_ready, then → WB_MEM.
- WB_MEM: we_rf=1, sel_result=01 → FETCH.
- MEM_WR: mem_req=1, we_mem=1, sel_mem_addr=1. Waits for mem_ready, then → FETCH.
- EXE_R: src_a=10, src_b=00, alu_op=10 → WB_ALU.
- EXE_I: src_a=10, src_b=01, alu_op=11 → WB_ALU.
- WB_ALU: we_rf=1, sel_result=00 → FETCH.
- BR: src_a=10, src_b=00, alu_op=01, sel_pc_src=1, pc_update=take → FETCH. take is decoded from funct3:
  - 000 = zero; 001 = !zero.
  - 100 = lt; 101 = !lt.
  - 110 = ltu; 111 = !ltu.
  - 010 and 011 are illegal.
- JUMP: we_rf=1, sel_result=10, pc_update=1, sel_pc_src=1 → FETCH.
- LUI: we_rf=1, sel_result=11 → FETCH.
- ILLEGAL handling: → TRAP when MC_FSM_TRAP_EN is defined, else → FETCH (treated as NOP). Applies to an illegal opcode in DECODE and an illegal branch funct3 in BR; in BR, pc_update is forced to 0.
- TRAP: all outputs 0, trap=1. The FSM stays in TRAP until rst.
- Wait states are FETCH, MEM_RD and MEM_WR.
  - The timeout counter increments each wait cycle with mem_ready=0 and clears on every state change.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready=0, the next state is TRAP.
  - When mem_ready and timeout occur in the same cycle, mem_ready wins.

## Timing
- Zero-wait latencies, in cycles:
  - 3: LUI.
  - 4: R-type, I-arith, SW, BRANCH, JAL, JALR, AUIPC.
  - 5: LW.
- Each memory wait cycle adds 1.
- The first mem_req is in the first clk edge window after rst deasserts.
- The datapath captures data_reg on the mem_ready cycle in MEM_RD. pc_update and we_ir in FETCH are Mealy outputs, gated by mem_ready in the same cycle.
- Asserting rst mid-instruction (including during a wait or in TRAP) immediately zeroes all outputs. No partial write may follow.

## Configuration
- MC_FSM_TRAP_EN defined:
  - TRAP state, timeout counter and trap output are present.
  - Illegal opcodes, illegal branch funct3 and memory timeouts trap.
- MC_FSM_TRAP_EN not defined:
  - Counter and TRAP state are removed; trap is tied to 0.
  - Waits are unbounded.
  - Illegal encodings return to FETCH with no writes.

## Structure
- Package mc_ctrl_pkg holds:
  - the state encoding;
  - the opcode constants (R, I-arith, LW, SW, BRANCH, JAL, JALR 1100111, LUI, AUIPC 0010111);
  - the select/alu_op encodings;
  - the funct3 branch codes.
- One combinational sub-module, mc_branch_cond: inputs funct3, zero, lt, ltu; outputs take and illegal.

## Test plan
- R-type add with mem_ready tied 1: state sequence FETCH, DECODE, EXE_R, WB_ALU, FETCH. we_rf pulses exactly once, in the 4th cycle.
- LW with mem_ready low for 3 cycles in MEM_RD: MEM_RD held 4 cycles with mem_req=1 and sel_mem_addr=1, then WB_MEM with we_rf=1 and sel_result=01.
- BNE (funct3 001):
  - zero=1: pc_update=0 in BR.
  - zero=0: pc_update=1 and sel_pc_src=1.
  - Repeat for BLTU with ltu=1 and ltu=0.
- JALR: EXE_ADDR has src_a=10; JUMP has we_rf=1, sel_result=10, pc_update=1; return to FETCH.
- MC_FSM_TRAP_EN, MEM_TIMEOUT=4, mem_ready held 0 in FETCH: TRAP entered after 4 FETCH cycles; trap=1 and mem_req=0 until rst. In a second run, mem_ready rising on the 4th cycle is accepted with no trap.
- Opcode 1111111, and rst asserted mid-WB_MEM:
  - With the macro: TRAP. Without it: FETCH with no writes.
  - The rst case zeroes outputs immediately and restarts at FETCH.
